xor_chain_decoder: RTL and testbench
====================================

XOR_CHAIN_DECODER -- requirements
Module: xor_chain_decoder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: number of chain taps per frame, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-006 SHALL have port in_sof, input, 1 bit: the beat is the frame seed (chain input A).
REQ-007 SHALL have port in_bit, input, 1 bit: the seed, or the next chain tap in order C, E, G, I, ...
REQ-008 SHALL have port out_valid, output, 1 bit: the decoded word is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the word.
REQ-010 SHALL have port out_data, output, FRAME_LEN bits: the recovered chain inputs; bit 0 = B, bit 1 = D, bit k = second input of gate k+1.
REQ-011 SHALL have port out_seed, output, 1 bit: the seed of the frame in out_data.
REQ-012 SHALL have port frame_cnt, output, 16 bits: frames delivered; wraps from 0xFFFF to 0.
REQ-013 SHALL have port err_cnt, output, 8 bits: frames aborted; saturates at 0xFF.

Function
REQ-014 SHALL treat a beat as accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-015 SHALL implement a state machine with three states: IDLE, COLLECT and HOLD.
REQ-016 SHALL drive in_ready to 1 in IDLE and COLLECT, and to 0 in HOLD.
REQ-017 In IDLE, an accepted beat with in_sof=1 SHALL store in_bit as the seed and as prev, clear the tap index, and go to COLLECT.
REQ-018 In IDLE, an accepted beat with in_sof=0 SHALL be discarded, with no change to state, data or counters.
REQ-019 In COLLECT, an accepted tap beat (in_sof=0) at index k SHALL write out_data bit k = in_bit XOR prev, set prev = in_bit, and increment k.
REQ-020 When the accepted tap has k = FRAME_LEN-1, the block SHALL go to HOLD and assert out_valid in the next cycle (latency: 1 cycle after the last tap).
REQ-021 In COLLECT, an accepted beat with in_sof=1 SHALL abort the current frame, increment err_cnt (saturating), load the new seed, reset k to 0, and stay in COLLECT.
REQ-022 out_valid SHALL be 1 only in HOLD.
REQ-023 out_data and out_seed SHALL be stable throughout HOLD.
REQ-024 In HOLD, when out_ready=1, the block SHALL increment frame_cnt (modulo 2^16) and go to IDLE in the next cycle.
REQ-025 Input beats presented during HOLD SHALL be back-pressured and not consumed.
REQ-026 out_data bits not yet written in the current frame SHALL hold 0; out_data SHALL be cleared on each seed load.
REQ-027 A gap in in_valid mid-frame SHALL stall collection with no loss of state.
REQ-028 The block SHALL sustain back-to-back frames at FRAME_LEN+2 cycles per frame when out_ready is held at 1.

Reset
REQ-029 While rst=1, the block SHALL force state IDLE, out_valid=0, in_ready=0, out_data=0, out_seed=0, frame_cnt=0, err_cnt=0, k=0 and prev=0.
REQ-030 Reset SHALL take priority over all other events; a partial frame or a word held in HOLD SHALL be dropped without counting.
REQ-031 in_ready SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-032 Seed 1, taps 0,0,1,0,0,0,1,1, out_ready=1 -> out_data=0x4D, out_seed=1, out_valid for 1 cycle, then frame_cnt=1.
REQ-033 Seed 1, taps all 0 -> out_data=0x01; seed 0, taps all 1 -> out_data=0x01.
REQ-034 out_ready held 0 for 5 cycles with a second frame presented -> in_ready=0, out_data held, and the second frame is decoded correctly after release.
REQ-035 A seed beat after 3 taps -> err_cnt=1 and the subsequent full frame decodes correctly; 300 such aborts -> err_cnt=0xFF.
REQ-036 rst asserted in COLLECT after 4 taps, and separately in HOLD -> all outputs match REQ-029 and no word is emitted.
REQ-037 65537 delivered frames -> frame_cnt=1; non-seed beats in IDLE -> ignored, with counters unchanged.

Source files
------------

// File: rtl/xor_chain_decoder.sv
// Recovers the second inputs of an XOR gate chain from its seed and successive chain taps.
// Frames are accepted on a valid/ready input and delivered as one word on a valid/ready output.
module xor_chain_decoder #(
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic                 in_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_seed,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt,
  output logic [1:0]           state_dbg
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and valid/data hold until the transfer happens.

  localparam int KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic          prev;
  logic          accept;
  logic          last_tap;
  logic          seed_load;

  assign accept    = in_valid && in_ready;
  assign last_tap  = (k == KW'(FRAME_LEN - 1));
  assign seed_load = accept && in_sof && (state == IDLE || state == COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && in_sof) state_nxt = COLLECT;
      COLLECT: if (accept && !in_sof && last_tap) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Both handshake outputs are masked by rst so they read 0 for the whole reset pulse.
  always_comb begin
    in_ready  = !rst && (state != HOLD);
    out_valid = !rst && (state == HOLD);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_seed  <= 1'b0;
      prev      <= 1'b0;
      k         <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (seed_load) begin
        out_data <= '0;
        out_seed <= in_bit;
        prev     <= in_bit;
        k        <= '0;
        // A seed while collecting abandons the partial frame.
        if (state == COLLECT && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (state == COLLECT && accept) begin
        out_data[k] <= in_bit ^ prev;
        prev        <= in_bit;
        k           <= last_tap ? '0 : k + KW'(1);
      end
      if (state == HOLD && out_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_xor_chain_decoder.sv
// Bench for xor_chain_decoder: scenario tasks drive frames, a monitor pops expected
// {seed, word} entries from a queue whenever a word is handed over.
module tb_xor_chain_decoder;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sof;
  logic         in_bit;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] out_data;
  logic         out_seed;
  logic [15:0]  frame_cnt;
  logic [7:0]   err_cnt;
  logic [1:0]   state_dbg;

  logic [L:0]   exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           exp_frames = 0;
  int           exp_errs = 0;

  xor_chain_decoder #(.FRAME_LEN(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_seed(out_seed), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Scoreboard: every delivered word must match the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      exp_frames++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got seed=%0b data=%02h, expected no word", out_seed, out_data);
      end else begin
        logic [L:0] e;
        e = exp_q.pop_front();
        if ({out_seed, out_data} !== e) begin
          n_bad++;
          $display("FAIL word: got seed=%0b data=%02h, expected seed=%0b data=%02h",
                   out_seed, out_data, e[L], e[L-1:0]);
        end
      end
    end
  end

  function automatic logic [L-1:0] model(input logic seed, input logic [L-1:0] taps);
    logic [L-1:0] r;
    logic         p;
    p = seed;
    for (int i = 0; i < L; i++) begin
      r[i] = taps[i] ^ p;
      p    = taps[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic sof, input logic b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_bit   = b;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, t);
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic seed, input logic [L-1:0] taps);
    send(1'b1, seed);
    for (int i = 0; i < L; i++) send(1'b0, taps[i]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      tick();
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d words pending, out_valid=%0b, expected 0 and 0",
               exp_q.size(), out_valid);
    end
    tick();
  endtask

  task automatic check_counters(input string tag);
    n_cmp++;
    if (frame_cnt !== 16'(exp_frames) || err_cnt !== 8'(exp_errs)) begin
      n_bad++;
      $display("FAIL %s_counters: got frame_cnt=%0d err_cnt=%0d, expected %0d and %0d",
               tag, frame_cnt, err_cnt, exp_frames, exp_errs);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_seed !== 1'b0 ||
        frame_cnt !== 16'd0 || err_cnt !== 8'd0 || state_dbg !== 2'd0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%0b vld=%0b data=%02h seed=%0b fc=%0d ec=%0d st=%0d, expected all 0",
               tag, in_ready, out_valid, out_data, out_seed, frame_cnt, err_cnt, state_dbg);
    end
  endtask

  task automatic apply_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_held");
    exp_frames = 0;
    exp_errs   = 0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if (in_ready !== 1'b1 || state_dbg !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%0b state=%0d, expected 1 and 0", in_ready, state_dbg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    apply_reset();
  endtask

  task automatic test_known_vectors();
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h4D});
    send_frame(1'b1, 8'b1100_0100);
    idle_in();
    wait_drain();
    check_counters("known_4d");
    n_cmp++;
    if (frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL first_frame_cnt: got %0d, expected 1", frame_cnt);
    end
    exp_q.push_back({1'b1, 8'h01});
    send_frame(1'b1, 8'h00);
    exp_q.push_back({1'b0, 8'h01});
    send_frame(1'b0, 8'hFF);
    idle_in();
    wait_drain();
    check_counters("known_01");
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic         s;
      logic [L-1:0] t;
      s = 1'($urandom_range(0, 1));
      t = L'($urandom_range(0, 255));
      exp_q.push_back({s, model(s, t)});
      send_frame(s, t);
      if ($urandom_range(0, 3) == 0) begin
        idle_in();
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    idle_in();
    wait_drain();
    check_counters("random");
  endtask

  task automatic test_gap();
    logic [L-1:0] t;
    out_ready = 1'b1;
    t = 8'hA6;
    exp_q.push_back({1'b1, model(1'b1, t)});
    send(1'b1, 1'b1);
    for (int i = 0; i < L; i++) begin
      send(1'b0, t[i]);
      idle_in();
      repeat (2) tick();
    end
    wait_drain();
    check_counters("gap");
  endtask

  task automatic test_back_to_back();
    realtime t0;
    realtime t1;
    logic [L-1:0] taps[4];
    logic         seeds[4];
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      seeds[n] = 1'($urandom_range(0, 1));
      taps[n]  = L'($urandom_range(0, 255));
      exp_q.push_back({seeds[n], model(seeds[n], taps[n])});
    end
    t0 = 0;
    t1 = 0;
    for (int n = 0; n < 4; n++) begin
      send(1'b1, seeds[n]);
      if (n == 0) t0 = $realtime;
      for (int i = 0; i < L; i++) send(1'b0, taps[n][i]);
    end
    t1 = $realtime;
    idle_in();
    wait_drain();
    n_cmp++;
    if (t1 - t0 != real'((3 * (L + 2) + L) * 10)) begin
      n_bad++;
      $display("FAIL back_to_back_time: got %0t, expected %0d", t1 - t0, (3 * (L + 2) + L) * 10);
    end
    check_counters("back_to_back");
  endtask

  task automatic test_backpressure();
    logic [L-1:0] ta;
    logic [L-1:0] tb;
    int w;
    ta = 8'h3C;
    tb = 8'h91;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, model(1'b0, ta)});
    exp_q.push_back({1'b1, model(1'b1, tb)});
    send_frame(1'b0, ta);
    w = 0;
    tick();
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== model(1'b0, ta) ||
          frame_cnt !== 16'(exp_frames)) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got rdy=%0b vld=%0b data=%02h fc=%0d, expected 0 1 %02h %0d",
                 c, in_ready, out_valid, out_data, frame_cnt, 0, 1, model(1'b0, ta), exp_frames);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    send_frame(1'b1, tb);
    idle_in();
    wait_drain();
    check_counters("backpressure");
  endtask

  task automatic test_abort();
    logic [L-1:0] t;
    out_ready = 1'b1;
    t = 8'h5B;
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    exp_errs++;
    exp_q.push_back({1'b1, model(1'b1, t)});
    send_frame(1'b1, t);
    idle_in();
    wait_drain();
    check_counters("abort_one");
    send(1'b1, 1'b1);
    for (int n = 0; n < 300; n++) send(1'b1, 1'(n));
    exp_errs = 255;
    exp_q.push_back({1'b1, model(1'b1, 8'h77)});
    for (int i = 0; i < L; i++) send(1'b0, t[i] ^ t[i] ^ 1'(8'h77 >> i));
    idle_in();
    wait_drain();
    check_counters("abort_saturate");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b0, 1'(i));
    apply_reset();
    repeat (12) tick();
    check_counters("reset_collect");
    out_ready = 1'b0;
    send_frame(1'b1, 8'hF0);
    idle_in();
    repeat (2) tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reach_hold: got out_valid=%0b, expected 1", out_valid);
    end
    apply_reset();
    out_ready = 1'b1;
    repeat (12) tick();
    check_counters("reset_hold");
  endtask

  task automatic test_idle_ignore();
    logic [L-1:0] d0;
    out_ready = 1'b1;
    d0 = out_data;
    for (int i = 0; i < 6; i++) send(1'b0, 1'(i));
    idle_in();
    tick();
    n_cmp++;
    if (state_dbg !== 2'd0 || out_data !== d0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore: got st=%0d data=%02h vld=%0b, expected 0 %02h 0",
               state_dbg, out_data, out_valid, d0);
    end
    check_counters("idle_ignore");
    exp_q.push_back({1'b0, model(1'b0, 8'h2E)});
    send_frame(1'b0, 8'h2E);
    idle_in();
    wait_drain();
    check_counters("after_ignore");
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_gap();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_idle_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
